// File: rtl/mem_pkg.sv
// Purpose: shared load/store encodings and helpers for the core M-stage and the data-memory responder.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mem_pkg;

  // funct3 access-size codes; 011/110/111 are illegal and fall to default arms
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  // one-entry store buffer occupancy
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // true for an illegal size code or an access that straddles its natural alignment
  function automatic logic access_fault(input logic [2:0] size, input logic [1:0] off);
    logic f;
    case (mem_size_e'(size))
      MEM_B, MEM_BU: f = 1'b0;
      MEM_H, MEM_HU: f = off[0];
      MEM_W:         f = (off != 2'b00);
      default:       f = 1'b1;
    endcase
    return f;
  endfunction

  // byte-enable mask for a store of the given size at byte offset off
  function automatic logic [3:0] store_mask(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (mem_size_e'(size))
      MEM_B, MEM_BU: m = 4'b0001 << off;
      MEM_H, MEM_HU: m = off[1] ? 4'b1100 : 4'b0011;
      MEM_W:         m = 4'b1111;
      default:       m = 4'b0000;
    endcase
    return m;
  endfunction

  // move right-aligned store data onto the byte lanes selected by off
  function automatic logic [31:0] store_lanes(input logic [31:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// Purpose: selects the addressed byte/half from a memory word and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module dmem_load_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [31:0] word,
  output logic [31:0] rd
);

  logic [31:0] lane;

  // shift the addressed lane down to bit 0, then extend according to the access size
  always_comb begin
    lane = word >> {off, 3'b000};
    case (mem_size_e'(size))
      MEM_B:   rd = {{24{lane[7]}}, lane[7:0]};
      MEM_BU:  rd = {24'h000000, lane[7:0]};
      MEM_H:   rd = {{16{lane[15]}}, lane[15:0]};
      MEM_HU:  rd = {16'h0000, lane[15:0]};
      MEM_W:   rd = lane;
      default: rd = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Purpose: data-memory responder with one-entry store buffer, masked stores and extended loads.
// Latency: load data/err one cycle after acceptance; stores commit on the first cycle without a load.
// Backpressure: req_ready drops for one cycle only when a load hits the buffered store's word.
module dmem_resp
  import mem_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [2:0]  mem_size,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        rsp_valid,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] req_widx;
  logic [1:0]        req_off;
  logic              req_fault;
  logic              hazard;
  logic              accept;
  logic              mem_rd;
  logic              mem_wr;
  logic              buf_fill;
  logic              unused_addr_bits;

  buf_state_e        buf_state_q, buf_state_d;
  logic [ADDR_W-1:0] buf_addr_q,  buf_addr_d;
  logic [3:0]        buf_mask_q,  buf_mask_d;
  logic [31:0]       buf_dat_q,   buf_dat_d;
  logic              rsp_vld_q,   rsp_vld_d;
  logic              rsp_ok_q,    rsp_ok_d;
  logic              err_q,       err_d;
  logic [1:0]        rsp_off_q,   rsp_off_d;
  logic [2:0]        rsp_size_q,  rsp_size_d;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       mem_rdata_q;
  logic [31:0]       fmt_rd;

  assign req_widx         = addr[ADDR_W+1:2];
  assign req_off          = addr[1:0];
  assign unused_addr_bits = ^addr[31:ADDR_W+2];
  assign req_fault        = access_fault(mem_size, req_off);

  // A load to the buffered word must wait for the drain (no forwarding path); stores never stall.
  assign hazard    = req_valid && !we && (buf_state_q == BUF_FULL) && (buf_addr_q == req_widx);
  assign req_ready = !hazard;

  // Nothing is accepted or committed while reset is asserted, so a buffered store is discarded.
  assign accept   = req_valid && req_ready && reset;
  assign mem_rd   = accept && !we && !req_fault;
  assign buf_fill = accept && we && !req_fault;
  assign mem_wr   = (buf_state_q == BUF_FULL) && !mem_rd && reset;

  // next-state for the store buffer and the response pipeline register
  always_comb begin
    buf_state_d = buf_state_q;
    buf_addr_d  = buf_addr_q;
    buf_mask_d  = buf_mask_q;
    buf_dat_d   = buf_dat_q;
    rsp_vld_d   = accept && !we;
    rsp_ok_d    = mem_rd;
    err_d       = accept && req_fault;
    rsp_off_d   = rsp_off_q;
    rsp_size_d  = rsp_size_q;

    if (mem_wr) begin
      buf_state_d = BUF_EMPTY;
    end
    // a new store refills in the same cycle the old entry drains
    if (buf_fill) begin
      buf_state_d = BUF_FULL;
      buf_addr_d  = req_widx;
      buf_mask_d  = store_mask(mem_size, req_off);
      buf_dat_d   = store_lanes(wd, req_off);
    end
    if (mem_rd) begin
      rsp_off_d  = req_off;
      rsp_size_d = mem_size;
    end
  end

  // control and buffer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_state_q <= BUF_EMPTY;
      buf_addr_q  <= '0;
      buf_mask_q  <= 4'b0000;
      buf_dat_q   <= 32'h0000_0000;
      rsp_vld_q   <= 1'b0;
      rsp_ok_q    <= 1'b0;
      err_q       <= 1'b0;
      rsp_off_q   <= 2'b00;
      rsp_size_q  <= 3'b000;
    end else begin
      buf_state_q <= buf_state_d;
      buf_addr_q  <= buf_addr_d;
      buf_mask_q  <= buf_mask_d;
      buf_dat_q   <= buf_dat_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_ok_q    <= rsp_ok_d;
      err_q       <= err_d;
      rsp_off_q   <= rsp_off_d;
      rsp_size_q  <= rsp_size_d;
    end
  end

  // single-port array: either a load read or a byte-masked drain write per cycle, never reset
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (buf_mask_q[b]) begin
          mem_q[buf_addr_q][8*b +: 8] <= buf_dat_q[8*b +: 8];
        end
      end
    end
    if (mem_rd) begin
      mem_rdata_q <= mem_q[req_widx];
    end
  end

  dmem_load_fmt u_fmt (
    .off  (rsp_off_q),
    .size (rsp_size_q),
    .word (mem_rdata_q),
    .rd   (fmt_rd)
  );

  // faulting loads and idle cycles present zero data
  assign rd        = rsp_ok_q ? fmt_rd : 32'h0000_0000;
  assign rsp_valid = rsp_vld_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Purpose: scoreboard bench for dmem_resp against a byte-addressed architectural memory model.
// Latency: expects load/err responses exactly one cycle after acceptance.
// Backpressure: driver holds each request until req_ready, bounded by a stall budget.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  mem_size = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wd = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic        err;
  logic [31:0] rd;

  always #5 clk = ~clk;

  dmem_resp #(.ADDR_W(18)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .we        (we),
    .mem_size  (mem_size),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd),
    .rsp_valid (rsp_valid),
    .err       (err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          due;
    bit          is_load;
    bit          is_err;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] mm [int unsigned];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // architectural view: program-order byte memory, alignment rules, extension rules
  function automatic bit m_fault(input logic [2:0] sz, input logic [31:0] a);
    case (sz)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      3'b010:         return a[1:0] != 2'b00;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic int m_bytes(input logic [2:0] sz);
    return (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
  endfunction

  task automatic m_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < m_bytes(sz); i++) mm[a + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = m_bytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (mm.exists(a + i)) v = v | (32'(mm[a + i]) << (8 * i));
    end
    if (!sz[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // drive one request, hold it until accepted, and book the expected response
  task automatic issue(input bit w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input bit commit, output int stalls);
    exp_t e;
    bit   done;
    bit   f;
    stalls = 0;
    done = 1'b0;
    req_valid = 1'b1; we = w; mem_size = sz; addr = a; wd = d;
    while (!done) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
      if (!done && stalls > 4) begin
        n_chk++; n_fail++;
        $display("FAIL req_ready_timeout: actual=stalled %0d cycles required=at most 1 (addr %h)", stalls, a);
        break;
      end
    end
    req_valid = 1'b0;
    if (done) begin
      f = m_fault(sz, a);
      if (!w || f) begin
        e.due = cyc; e.is_load = !w; e.is_err = f;
        e.rd = (!w && !f) ? m_load(sz, a) : 32'h0;
        exp_q.push_back(e);
      end
      if (w && !f && commit) m_store(sz, a, d);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // monitor: pop the scoreboard when a response is due, otherwise outputs must be quiet
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL missed_response: actual=none required=response due cycle %0d", exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, mon_e.is_load});
        chk("err", {31'b0, err}, {31'b0, mon_e.is_err});
        chk("rd", rd, mon_e.rd);
      end else begin
        chk("idle_vld_err", {30'b0, rsp_valid, err}, 32'h0);
        chk("idle_rd", rd, 32'h0);
      end
    end
  end

  initial begin
    int st;
    logic [2:0] sz;
    logic [2:0] bad [3];
    bad[0] = 3'b011; bad[1] = 3'b110; bad[2] = 3'b111;

    // reset state
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    chk("reset_rd", rd, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    idle(1);

    // prior contents for the reset-discard case
    issue(1'b1, 3'b010, 32'h30, 32'h1122_3344, 1'b1, st);
    idle(2);

    // store then immediate load of the same word: one-cycle hazard stall
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b1, st);
    chk("sw_no_stall", st, 0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, st);
    chk("lw_hazard_stall", st, 1);
    issue(1'b0, 3'b000, 32'h11, 32'h0, 1'b1, st);
    issue(1'b0, 3'b100, 32'h11, 32'h0, 1'b1, st);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, st);
    issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b1, st);
    chk("lhu_no_stall", st, 0);

    // sub-word stores merge into the existing word
    issue(1'b1, 3'b000, 32'h13, 32'h0000_007F, 1'b1, st);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, st);
    issue(1'b1, 3'b001, 32'h10, 32'h0000_1234, 1'b1, st);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, st);

    // misaligned load and store: err pulses, load returns zero, memory unchanged
    issue(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, st);
    issue(1'b1, 3'b001, 32'h11, 32'hFFFF_FFFF, 1'b1, st);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, st);
    idle(2);

    // back-to-back stores never stall; only the load of the last-buffered word does
    issue(1'b1, 3'b010, 32'h20, 32'h1, 1'b1, st); chk("sw20_stall", st, 0);
    issue(1'b1, 3'b010, 32'h24, 32'h2, 1'b1, st); chk("sw24_stall", st, 0);
    issue(1'b1, 3'b010, 32'h28, 32'h3, 1'b1, st); chk("sw28_stall", st, 0);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, st); chk("lw20_stall", st, 0);
    issue(1'b0, 3'b010, 32'h24, 32'h0, 1'b1, st); chk("lw24_stall", st, 0);
    issue(1'b0, 3'b010, 32'h28, 32'h0, 1'b1, st); chk("lw28_stall", st, 1);
    idle(2);

    // reset right after a store discards the buffered entry
    issue(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 1'b0, st);
    reset = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("inreset_req_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1 reset = 1'b1;
    idle(1);
    issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b1, st);
    chk("lw30_after_reset_stall", st, 0);
    idle(2);

    // randomized traffic over a pre-initialised window
    for (int i = 0; i < 16; i++) issue(1'b1, 3'b010, 32'h40 + 32'(4 * i), $urandom, 1'b1, st);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    sz = 3'b000;
        2, 3:    sz = 3'b001;
        4, 5:    sz = 3'b010;
        6:       sz = 3'b100;
        7, 8:    sz = 3'b101;
        default: sz = bad[$urandom_range(0, 2)];
      endcase
      if ($urandom_range(0, 7) == 0) idle(1);
      issue(1'($urandom_range(0, 1)), sz, 32'h40 + 32'($urandom_range(0, 63)), $urandom, 1'b1, st);
    end
    idle(4);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
